// File: rtl/serial_nibble_subtractor_pkg.sv
// serial_nibble_subtractor_pkg: shared FSM state type and slice width
package serial_nibble_subtractor_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/serial_nibble_subtractor_nibble_prefix_sub.sv
// nibble_prefix_sub: 4-bit x + ~y + cin using Brent-Kung prefix carries
module nibble_prefix_sub
  import serial_nibble_subtractor_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] d,
  output logic               cout
);
  logic [3:0] p, g;
  logic g0, g10, g32, p32, g20, g30;
  assign p = x ^ ~y;
  assign g = x & ~y;
  // carry-in folded into bit 0 generate so every group term spans down to cin
  assign g0 = g[0] | (p[0] & cin);
  assign g10 = g[1] | (p[1] & g0);
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g30 = g32 | (p32 & g10);
  assign g20 = g[2] | (p[2] & g10);
  assign d = p ^ {g20, g10, g0, cin};
  assign cout = g30;
endmodule

// File: rtl/serial_nibble_subtractor.sv
// serial_nibble_subtractor: a - b computed one nibble per cycle with valid/ready handshakes
module serial_nibble_subtractor
  import serial_nibble_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);
  localparam int N = WIDTH / SLICE_W;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [SLICE_W-1:0] s;
  logic co, last;
  nibble_prefix_sub u_sub (
    .x   (a_q[idx_q*SLICE_W +: SLICE_W]),
    .y   (b_q[idx_q*SLICE_W +: SLICE_W]),
    .cin (carry_q),
    .d   (s),
    .cout(co)
  );
  assign last = idx_q == IW'(N - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    diff_d = diff_q;
    idx_d = idx_q;
    carry_d = carry_q;
    borrow_d = borrow_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = BUSY;
        a_d = a;
        b_d = b;
        idx_d = '0;
        carry_d = 1'b1;
      end
      BUSY: begin
        diff_d[idx_q*SLICE_W +: SLICE_W] = s;
        carry_d = co;
        idx_d = idx_q + 1'b1;
        if (last) begin
          state_d = DONE;
          borrow_d = ~co;
          ovf_d = (a_q[MSB] != b_q[MSB]) && (s[SLICE_W-1] != a_q[MSB]);
          zero_d = diff_d == '0;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      diff_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      diff_q <= diff_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      borrow_q <= borrow_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign diff = diff_q;
  assign borrow_out = borrow_q;
  assign overflow = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_serial_nibble_subtractor.sv
// tb_serial_nibble_subtractor: directed and random checks of the serial nibble subtractor
module tb_serial_nibble_subtractor;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, borrow_out, overflow, zero;
  logic [15:0] diff;
  int errors = 0, checks = 0, cyc = 0;

  serial_nibble_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
    .borrow_out(borrow_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic start_op(input logic [15:0] x, input logic [15:0] y, output int lat);
    a = x;
    b = y;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_op;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hs: in_ready,out_valid=%b expected 10", {in_ready, out_valid});
    end
    checks++;
    if ({diff, borrow_out, overflow, zero} !== 19'd0) begin
      errors++;
      $display("FAIL reset_out: diff=%h flags=%b expected 0000/000", diff, {borrow_out, overflow, zero});
    end
    rst = 0;
  endtask

  task automatic test_vectors;
    logic [15:0] va [6] = '{16'h1234, 16'h0000, 16'h8000, 16'hABCD, 16'h0005, 16'h7FFF};
    logic [15:0] vb [6] = '{16'h0234, 16'h0001, 16'h0001, 16'hABCD, 16'h0003, 16'hFFFF};
    logic [15:0] vd [6] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0002, 16'h8000};
    logic [2:0]  vf [6] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b110};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i], lat);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL vec%0d_latency: %0d cycles expected 4", i, lat);
      end
      checks++;
      if (diff !== vd[i]) begin
        errors++;
        $display("FAIL vec%0d_diff: %h expected %h", i, diff, vd[i]);
      end
      checks++;
      if ({borrow_out, overflow, zero} !== vf[i]) begin
        errors++;
        $display("FAIL vec%0d_flags: %b expected %b", i, {borrow_out, overflow, zero}, vf[i]);
      end
      release_op();
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL vec%0d_idle: in_ready,out_valid=%b expected 10", i, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(16'h0000, 16'h0001, lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({in_ready, out_valid, diff, borrow_out, overflow, zero} !== {2'b01, 16'hFFFF, 3'b100}) begin
        errors++;
        $display("FAIL hold%0d: rdy,vld=%b diff=%h flags=%b expected 01/ffff/100", i,
                 {in_ready, out_valid}, diff, {borrow_out, overflow, zero});
      end
      @(posedge clk); #1;
    end
    release_op();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL hold_release: in_ready,out_valid=%b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid;
    int lat, pulses;
    a = 16'h1111;
    b = 16'h0001;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, diff, borrow_out, overflow, zero} !== {2'b10, 19'd0}) begin
      errors++;
      $display("FAIL midrst_state: rdy,vld=%b diff=%h flags=%b expected 10/0000/000",
               {in_ready, out_valid}, diff, {borrow_out, overflow, zero});
    end
    rst = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      pulses += int'(out_valid);
    end
    checks++;
    if (pulses !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_abort: out_valid pulses=%0d in_ready=%b expected 0/1", pulses, in_ready);
    end
    start_op(16'h0005, 16'h0003, lat);
    checks++;
    if (lat !== 4 || diff !== 16'h0002) begin
      errors++;
      $display("FAIL midrst_next: lat=%0d diff=%h expected 4/0002", lat, diff);
    end
    release_op();
  endtask

  task automatic test_back_to_back;
    logic [15:0] x, y, md;
    logic [16:0] w;
    logic [2:0] mf;
    int t_acc, t_prev, wait_n;
    in_valid = 1;
    out_ready = 1;
    t_prev = -1;
    for (int n = 0; n < 1000; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      a = x;
      b = y;
      wait_n = 0;
      while (!in_ready && wait_n < 20) begin
        @(posedge clk); #1;
        wait_n++;
      end
      @(posedge clk);
      t_acc = cyc;
      #1;
      a = 16'($urandom);
      b = 16'($urandom);
      w = {1'b0, x} - {1'b0, y};
      md = w[15:0];
      mf = {w[16], (x[15] != y[15]) && (md[15] != x[15]), md == 16'h0};
      wait_n = 0;
      while (!out_valid && wait_n < 20) begin
        @(posedge clk); #1;
        wait_n++;
      end
      checks++;
      if (diff !== md || {borrow_out, overflow, zero} !== mf || wait_n !== 4) begin
        errors++;
        $display("FAIL rand%0d %h-%h: diff=%h flags=%b lat=%0d expected %h/%b/4", n, x, y,
                 diff, {borrow_out, overflow, zero}, wait_n, md, mf);
      end
      if (t_prev >= 0) begin
        checks++;
        if (t_acc - t_prev !== 6) begin
          errors++;
          $display("FAIL rand%0d_interval: %0d cycles expected 6", n, t_acc - t_prev);
        end
      end
      t_prev = t_acc;
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
